// File: rtl/biquad_iir_mc_pkg.sv
// Package iir_pkg: shared types and helpers for the biquad_iir_mc slice.
//   tap_e      - coefficient/tap index (b0, b1, b2, a1, a2)
//   state_e    - sequencer states of the time-multiplexed MAC
//   acc_width  - accumulator width for a given sample/coefficient width
//   sat_needed - true when a (sign-extended) value exceeds a dw-bit signed range
package iir_pkg;

  typedef enum logic [2:0] {
    TAP_B0, TAP_B1, TAP_B2, TAP_A1, TAP_A2
  } tap_e;

  typedef enum logic [2:0] {
    S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_WB, S_OUT
  } state_e;

  localparam int unsigned NUM_TAPS = 5;
  // Widest accumulator the saturation helper can inspect.
  localparam int unsigned SAT_MAXW = 128;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw);
    return dw + cw + 3;
  endfunction

  function automatic logic sat_needed(input logic signed [SAT_MAXW-1:0] v,
                                      input int unsigned dw);
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    hi = (SAT_MAXW'(1) << (dw - 1)) - SAT_MAXW'(1);
    lo = ~hi;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/biquad_iir_mc_if.sv
// Stream interface of biquad_iir_mc: sample input (valid/ready/chan/data)
// and filtered output (valid/ready/chan/data/sat).
//   master - producer of samples / consumer of results (front end side)
//   slave  - the filter itself
interface biquad_iir_mc_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_chan;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               out_chan;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_chan, in_data, out_ready,
    input  in_ready, out_valid, out_chan, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_chan, in_data, out_ready,
    output in_ready, out_valid, out_chan, out_data, out_sat
  );
endinterface

// File: rtl/biquad_iir_mc_hist.sv
// biquad_hist_ram: per-channel history register file, CHANNELS entries of
// W bits ({y2, y1, x2, x1} as packed by the top).
//   insclk  - clock            rst     - sync reset, clears every entry
//   rd_en   - registered read  rd_addr - channel to read, rd_data - held value
//   we      - write enable     wr_addr - channel to write, wr_data - new value
module biquad_hist_ram #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned AW       = 2,
  parameter int unsigned W        = 128
) (
  input  logic          insclk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);
  logic [W-1:0] mem [CHANNELS];

  always_ff @(posedge insclk) begin
    if (rst) begin
      mem     <= '{default: '0};
      rd_data <= '0;
    end else begin
      if (we)    mem[wr_addr] <= wr_data;
      if (rd_en) rd_data      <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/biquad_iir_mc.sv
// biquad_iir_mc: multi-channel time-multiplexed direct-form-I biquad with one
// shared multiplier, per-channel history and saturated output.
//   insclk - clock, rst - synchronous active-high reset
//   bus    - biquad_iir_mc_if.slave (in_valid/in_ready/in_chan/in_data,
//            out_valid/out_ready/out_chan/out_data/out_sat)
// Optional macro IIR_COEF_LOAD_EN adds cfg_we/cfg_addr/cfg_data for a
// shadow coefficient bank that becomes active on the next accepted sample.
module biquad_iir_mc
  import iir_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int CHANNELS  = 4,
  parameter int B0        = 8192,
  parameter int B1        = -16384,
  parameter int B2        = 8192,
  parameter int A1        = 32046,
  parameter int A2        = -15679
) (
  input  logic                     insclk,
  input  logic                     rst,
`ifdef IIR_COEF_LOAD_EN
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
`endif
  biquad_iir_mc_if.slave           bus
);
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned AW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned HW     = 4 * DATA_W;
  localparam logic signed [COEF_W-1:0] COEF_DEF [NUM_TAPS] =
    '{COEF_W'(B0), COEF_W'(B1), COEF_W'(B2), COEF_W'(A1), COEF_W'(A2)};

  state_e                   state_q, state_d;
  logic [3:0]               chan_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_sh;
  logic [HW-1:0]            hist_rd;
  logic signed [DATA_W-1:0] h_x1, h_x2, h_y1, h_y2;
  logic signed [DATA_W-1:0] mul_a;
  logic signed [COEF_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  tap_e                     tap;
  logic                     accept, in_range, sat;
  logic signed [DATA_W-1:0] y_sat;
  logic [3:0]               out_chan_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_sat_q;
  logic signed [COEF_W-1:0] coef_act [NUM_TAPS];

  assign {h_y2, h_y1, h_x2, h_x1} = hist_rd;
  assign accept   = (state_q == S_IDLE) && bus.in_valid;
  assign in_range = int'(bus.in_chan) < CHANNELS;

`ifdef IIR_COEF_LOAD_EN
  logic signed [COEF_W-1:0] coef_shd [NUM_TAPS];

  // Shadow-to-active copy happens only on an accept edge so a sample in
  // flight always sees one coherent coefficient set.
  always_ff @(posedge insclk) begin
    if (rst) begin
      coef_shd <= COEF_DEF;
      coef_act <= COEF_DEF;
    end else begin
      if (cfg_we && (cfg_addr <= 3'd4)) coef_shd[cfg_addr] <= cfg_data;
      if (accept) coef_act <= coef_shd;
    end
  end
`else
  assign coef_act = COEF_DEF;
`endif

  // Shared multiplier: the MAC state selects the tap and its operand.
  always_comb begin
    tap   = TAP_B0;
    mul_a = '0;
    case (state_q)
      S_MAC0:  begin tap = TAP_B0; mul_a = x_q;  end
      S_MAC1:  begin tap = TAP_B1; mul_a = h_x1; end
      S_MAC2:  begin tap = TAP_B2; mul_a = h_x2; end
      S_MAC3:  begin tap = TAP_A1; mul_a = h_y1; end
      S_MAC4:  begin tap = TAP_A2; mul_a = h_y2; end
      default: begin tap = TAP_B0; mul_a = '0;   end
    endcase
  end

  assign mul_b  = coef_act[tap];
  assign prod   = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign acc_sh = acc_q >>> COEF_FRAC;
  assign sat    = sat_needed(SAT_MAXW'(acc_sh), DATA_W);
  assign y_sat  = !sat ? acc_sh[DATA_W-1:0]
                : (acc_sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}});

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && in_range) state_d = S_MAC0;
      end
      S_MAC0:  state_d = S_MAC1;
      S_MAC1:  state_d = S_MAC2;
      S_MAC2:  state_d = S_MAC3;
      S_MAC3:  state_d = S_MAC4;
      S_MAC4:  state_d = S_WB;
      S_WB:    state_d = S_OUT;
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge insclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      chan_q     <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      out_chan_q <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && in_range) begin
        chan_q <= bus.in_chan;
        x_q    <= bus.in_data;
        acc_q  <= '0;
      end
      if (state_q inside {S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4})
        acc_q <= acc_q + ACC_W'(prod);
      if (state_q == S_WB) begin
        out_chan_q <= chan_q;
        out_data_q <= y_sat;
        out_sat_q  <= sat;
      end
    end
  end

  assign bus.out_chan = out_chan_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sat  = out_sat_q;

  // Read latched at accept stays stable until the WB write of the new history.
  biquad_hist_ram #(
    .CHANNELS(CHANNELS),
    .AW      (AW),
    .W       (HW)
  ) u_hist (
    .insclk (insclk),
    .rst    (rst),
    .rd_en  (accept && in_range),
    .rd_addr(bus.in_chan[AW-1:0]),
    .rd_data(hist_rd),
    .we     (state_q == S_WB),
    .wr_addr(chan_q[AW-1:0]),
    .wr_data({h_y1, y_sat, h_x1, x_q})
  );
endmodule

// File: tb/tb_biquad_iir_mc.sv
module tb_biquad_iir_mc;
  logic insclk = 1'b0;
  logic rst;
  always #5 insclk = ~insclk;

  biquad_iir_mc_if #(.DATA_W(32)) a ();
  biquad_iir_mc_if #(.DATA_W(32)) b ();

`ifdef IIR_COEF_LOAD_EN
  logic               cfg_we, cfg_we_b;
  logic [2:0]         cfg_addr;
  logic signed [15:0] cfg_data;
`endif

  biquad_iir_mc #(
    .DATA_W(32), .COEF_W(16), .COEF_FRAC(15), .CHANNELS(4)
  ) dut_a (
    .insclk(insclk),
    .rst   (rst),
`ifdef IIR_COEF_LOAD_EN
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`endif
    .bus   (a.slave)
  );

  biquad_iir_mc #(
    .DATA_W(32), .COEF_W(16), .COEF_FRAC(12), .CHANNELS(4),
    .B0(32767), .B1(0), .B2(0), .A1(0), .A2(0)
  ) dut_b (
    .insclk(insclk),
    .rst   (rst),
`ifdef IIR_COEF_LOAD_EN
    .cfg_we(cfg_we_b), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`endif
    .bus   (b.slave)
  );

  int total  = 0;
  int passed = 0;

  // Reference model: per-channel history and the difference equation.
  longint mx1[16], mx2[16], my1[16], my2[16];

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endtask

  task automatic model_step(input int ch, input longint x, input longint c0, input longint c1,
                            input longint c2, input longint c3, input longint c4, input int frac,
                            output longint y, output bit s);
    longint acc, sh;
    acc = c0 * x + c1 * mx1[ch] + c2 * mx2[ch] + c3 * my1[ch] + c4 * my2[ch];
    sh  = acc >>> frac;
    s   = 1'b0;
    y   = sh;
    if (sh > 64'sd2147483647)       begin y = 64'sd2147483647;  s = 1'b1; end
    else if (sh < -64'sd2147483648) begin y = -64'sd2147483648; s = 1'b1; end
    mx2[ch] = mx1[ch]; mx1[ch] = x;
    my2[ch] = my1[ch]; my1[ch] = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge insclk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One transaction on DUT A; ok=0 if the input was never ready or no result came.
  task automatic xact(input logic [3:0] ch, input logic [31:0] d, input int stall,
                      output bit ok, output logic signed [31:0] od, output logic [3:0] oc,
                      output logic os, output int lat);
    ok = 1'b0; lat = 0; od = '0; oc = '0; os = 1'b0;
    for (int i = 0; i < 20 && !a.in_ready; i++) begin @(posedge insclk); #1; end
    if (!a.in_ready) return;
    a.in_chan = ch; a.in_data = d; a.in_valid = 1'b1; a.out_ready = (stall == 0);
    @(posedge insclk); #1;
    a.in_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge insclk); #1;
      if (a.out_valid) begin
        ok = 1'b1; lat = n; od = a.out_data; oc = a.out_chan; os = a.out_sat;
        break;
      end
    end
    if (ok) begin
      repeat (stall) begin @(posedge insclk); #1; end
      a.out_ready = 1'b1;
      @(posedge insclk); #1;
    end
    a.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    a.in_valid = 1'b1; a.in_chan = 4'd0; a.in_data = 32'd1000;
    rst = 1'b1;
    @(posedge insclk); #1;
    rst = 1'b0; a.in_valid = 1'b0;
    model_clear();
    total++; if (a.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", a.in_ready); else passed++;
    total++; if (a.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", a.out_valid); else passed++;
    total++; if (a.out_data !== 32'd0) $display("FAIL reset_out_data got=%0d exp=0", a.out_data); else passed++;
    total++; if (a.out_chan !== 4'd0) $display("FAIL reset_out_chan got=%0d exp=0", a.out_chan); else passed++;
    total++; if (a.out_sat !== 1'b0) $display("FAIL reset_out_sat got=%b exp=0", a.out_sat); else passed++;
  endtask

  task automatic test_impulse();
    bit ok; logic signed [31:0] od; logic [3:0] oc; logic os; int lat;
    do_reset();
    xact(4'd0, 32'd1000, 0, ok, od, oc, os, lat);
    total++; if (!ok) $display("FAIL imp0_valid got=none exp=out_valid"); else passed++;
    total++; if (lat != 6) $display("FAIL imp0_latency got=%0d exp=6", lat); else passed++;
    total++; if (od !== 32'sd250) $display("FAIL imp0_data got=%0d exp=250", od); else passed++;
    total++; if (oc !== 4'd0 || os !== 1'b0) $display("FAIL imp0_chan_sat got=%0d/%b exp=0/0", oc, os); else passed++;
    xact(4'd0, 32'd0, 0, ok, od, oc, os, lat);
    total++; if (!ok || od !== -32'sd256) $display("FAIL imp1_data got=%0d ok=%b exp=-256", od, ok); else passed++;
    total++; if (oc !== 4'd0 || os !== 1'b0) $display("FAIL imp1_chan_sat got=%0d/%b exp=0/0", oc, os); else passed++;
  endtask

  task automatic test_isolation();
    bit ok; logic signed [31:0] od; logic [3:0] oc; logic os; int lat;
    do_reset();
    xact(4'd0, 32'd1000, 0, ok, od, oc, os, lat);
    total++; if (!ok || od !== 32'sd250) $display("FAIL iso_step1 got=%0d ok=%b exp=250", od, ok); else passed++;
    xact(4'd1, 32'd0, 0, ok, od, oc, os, lat);
    total++; if (!ok || od !== 32'sd0 || oc !== 4'd1) $display("FAIL iso_step2 got=%0d ch=%0d exp=0 ch=1", od, oc); else passed++;
    xact(4'd0, 32'd0, 0, ok, od, oc, os, lat);
    total++; if (!ok || od !== -32'sd256 || oc !== 4'd0) $display("FAIL iso_step3 got=%0d ch=%0d exp=-256 ch=0", od, oc); else passed++;
  endtask

  task automatic test_saturation();
    logic [31:0] xs [2];
    logic [31:0] es [2];
    bit seen;
    xs[0] = 32'h7FFFFFFF; es[0] = 32'h7FFFFFFF;
    xs[1] = 32'h80000000; es[1] = 32'h80000000;
    do_reset();
    b.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20 && !b.in_ready; i++) begin @(posedge insclk); #1; end
      b.in_chan = 4'd0; b.in_data = xs[k]; b.in_valid = 1'b1;
      @(posedge insclk); #1;
      b.in_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 30 && !seen; n++) begin
        @(posedge insclk); #1;
        if (b.out_valid) seen = 1'b1;
      end
      total++; if (!seen) $display("FAIL sat%0d_valid got=none exp=out_valid", k); else passed++;
      total++; if (b.out_data !== es[k]) $display("FAIL sat%0d_data got=%h exp=%h", k, b.out_data, es[k]); else passed++;
      total++; if (b.out_sat !== 1'b1) $display("FAIL sat%0d_flag got=%b exp=1", k, b.out_sat); else passed++;
      @(posedge insclk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] d0; logic [3:0] c0; bit seen;
    do_reset();
    a.out_ready = 1'b0;
    a.in_chan = 4'd2; a.in_data = 32'd1000; a.in_valid = 1'b1;
    @(posedge insclk); #1;
    a.in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(posedge insclk); #1;
      if (a.out_valid) seen = 1'b1;
    end
    d0 = a.out_data; c0 = a.out_chan;
    total++; if (!seen || d0 !== 32'sd250 || c0 !== 4'd2) $display("FAIL bp_first got=%0d ch=%0d exp=250 ch=2", d0, c0); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(posedge insclk); #1;
      total++;
      if (a.out_valid !== 1'b1 || a.out_data !== 32'sd250 || a.out_chan !== 4'd2 || a.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got=v%b d%0d c%0d r%b exp=v1 d250 c2 r0", i, a.out_valid, a.out_data, a.out_chan, a.in_ready);
      else passed++;
    end
    a.out_ready = 1'b1;
    @(posedge insclk); #1;
    total++; if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0) $display("FAIL bp_release got=r%b v%b exp=r1 v0", a.in_ready, a.out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok; logic signed [31:0] od; logic [3:0] oc; logic os; int lat; bit seen;
    do_reset();
    a.in_chan = 4'd0; a.in_data = 32'd1000; a.in_valid = 1'b1;
    @(posedge insclk); #1;
    a.in_valid = 1'b0;
    repeat (2) begin @(posedge insclk); #1; end
    rst = 1'b1;
    @(posedge insclk); #1;
    rst = 1'b0;
    model_clear();
    total++; if (a.in_ready !== 1'b1) $display("FAIL rmid_idle got=%b exp=1", a.in_ready); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge insclk); #1; if (a.out_valid) seen = 1'b1; end
    total++; if (seen) $display("FAIL rmid_no_out got=out_valid exp=none"); else passed++;
    xact(4'd0, 32'd1000, 0, ok, od, oc, os, lat);
    total++; if (!ok || od !== 32'sd250) $display("FAIL rmid_after got=%0d ok=%b exp=250", od, ok); else passed++;
  endtask

  task automatic test_out_of_range();
    bit ok; logic signed [31:0] od; logic [3:0] oc; logic os; int lat; bit seen;
    do_reset();
    a.in_chan = 4'd5; a.in_data = 32'd1000; a.in_valid = 1'b1;
    @(posedge insclk); #1;
    a.in_valid = 1'b0;
    total++; if (a.in_ready !== 1'b1) $display("FAIL oor_idle got=%b exp=1", a.in_ready); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge insclk); #1; if (a.out_valid) seen = 1'b1; end
    total++; if (seen) $display("FAIL oor_no_out got=out_valid exp=none"); else passed++;
    xact(4'd0, 32'd1000, 0, ok, od, oc, os, lat);
    total++; if (!ok || od !== 32'sd250) $display("FAIL oor_after got=%0d ok=%b exp=250", od, ok); else passed++;
  endtask

  task automatic test_random();
    bit ok; logic signed [31:0] od; logic [3:0] oc; logic os; int lat;
    logic [3:0] ch; logic [31:0] x; int stall; longint y; bit s; logic [31:0] ey;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      ch    = 4'($urandom_range(0, 5));
      x     = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                          : 32'($urandom_range(0, 131071)) - 32'd65536;
      stall = $urandom_range(0, 3);
      xact(ch, x, stall, ok, od, oc, os, lat);
      total++;
      if (ch >= 4'd4) begin
        if (ok) $display("FAIL rnd%0d_oor got=out_valid exp=none", t); else passed++;
      end else begin
        model_step(int'(ch), longint'($signed(x)), 8192, -16384, 8192, 32046, -15679, 15, y, s);
        ey = y[31:0];
        if (!ok || od !== ey || oc !== ch || os !== s)
          $display("FAIL rnd%0d got=%0d ch%0d s%b ok%b exp=%0d ch%0d s%b", t, od, oc, os, ok, $signed(ey), ch, s);
        else passed++;
      end
    end
  endtask

`ifdef IIR_COEF_LOAD_EN
  task automatic test_coef_load();
    bit ok; logic signed [31:0] od; logic [3:0] oc; logic os; int lat; bit seen;
    do_reset();
    a.in_chan = 4'd0; a.in_data = 32'd1000; a.in_valid = 1'b1;
    @(posedge insclk); #1;
    a.in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'sd16384;
    @(posedge insclk); #1;
    cfg_addr = 3'd5; cfg_data = 16'sd0;
    @(posedge insclk); #1;
    cfg_we = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (a.out_valid) seen = 1'b1; else begin @(posedge insclk); #1; end
    end
    total++; if (!seen || a.out_data !== 32'sd250) $display("FAIL cfg_current got=%0d exp=250", a.out_data); else passed++;
    @(posedge insclk); #1;
    xact(4'd2, 32'd1000, 0, ok, od, oc, os, lat);
    total++; if (!ok || od !== 32'sd500) $display("FAIL cfg_next got=%0d ok=%b exp=500", od, ok); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    a.in_valid = 1'b0; a.in_chan = '0; a.in_data = '0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_chan = '0; b.in_data = '0; b.out_ready = 1'b1;
`ifdef IIR_COEF_LOAD_EN
    cfg_we = 1'b0; cfg_we_b = 1'b0; cfg_addr = '0; cfg_data = '0;
`endif
    model_clear();
    repeat (2) @(posedge insclk);
    #1;
    test_reset();
    test_impulse();
    test_isolation();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    test_random();
`ifdef IIR_COEF_LOAD_EN
    test_coef_load();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
